rv_dpsram: RTL and testbench
============================

Name: rv_dpsram

Overview:
Parametrised two-port (1 write + 1 read) synchronous SRAM. It is the successor to the single-port SRAM and serves register-file, cache-tag and scratchpad storage in the rv32i pipeline.
- Generalises width and depth.
- Adds per-byte write enables, a registered read with valid, and a write-first collision bypass.
- Clears the array with a hardware sweep after reset; a ready flag gates access until the sweep completes.

Parameters:
BW_DATA, 32, data width in bits; must be a multiple of 8
BW_ADDR, 4, address width; depth DEPTH = 2**BW_ADDR
BW_BE, BW_DATA/8, derived byte-enable width; not overridden

Ports:
i_dpsram_clk  input  1  clock, all logic on rising edge
i_dpsram_rstn  input  1  reset, synchronous, active-low
i_dpsram_wr_en  input  1  write request
i_dpsram_wr_addr  input  BW_ADDR  write address
i_dpsram_wr_data  input  BW_DATA  write data
i_dpsram_wr_be  input  BW_BE  byte enables; bit k selects bits [8k+7:8k]
i_dpsram_rd_en  input  1  read request
i_dpsram_rd_addr  input  BW_ADDR  read address
o_dpsram_rd_data  output  BW_DATA  registered read data
o_dpsram_rd_val  output  1  read data valid, one pulse per accepted read
o_dpsram_rdy  output  1  array initialised; requests accepted only when high

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low.
- Reset values: o_dpsram_rdy=0, o_dpsram_rd_val=0, o_dpsram_rd_data=0, FSM=INIT, sweep counter=0.
- FSM states are INIT and READY.
  - INIT: each cycle writes 0 to mem[cnt] and increments cnt.
  - At cnt==DEPTH-1, after the final write, the FSM moves to READY. The counter must not wrap into a second sweep.
  - INIT lasts exactly DEPTH cycles after reset deassertion. o_dpsram_rdy rises on the following cycle.
  - READY: held until the next reset.
- Requests while rdy=0: wr_en and rd_en are ignored. No write occurs, and rd_val stays 0.
- Write (rdy=1, wr_en=1): at the clock edge, mem[wr_addr] byte k <= wr_data byte k for each set be[k]; other bytes are unchanged. be=0 is a no-op.
- Read (rdy=1, rd_en=1 at cycle N):
  - o_dpsram_rd_data and o_dpsram_rd_val=1 appear at cycle N+1.
  - Latency is 1, and one read per cycle is sustained (back-to-back).
- rd_val is high only in the cycle after an accepted read.
- rd_data holds its last value when no read is accepted. It is not cleared except by reset.
- Collision (accepted read and write, same address, same cycle): write-first.
  - Returned byte k = wr_data byte k if be[k] is set, else the old mem byte.
  - Different addresses: independent, with no interaction.
- Reset mid-operation (rstn=0 in any state):
  - A pending read's rd_val is dropped next cycle (rd_val=0).
  - The FSM re-enters INIT and the full sweep reruns.
  - A write in the same cycle as reset does not take effect.
- Out-of-range addresses cannot occur; all 2**BW_ADDR locations exist.
- Elaboration error if BW_DATA % 8 != 0.

Optional Feature:
Macro: RV_DPSRAM_OREG_EN
- Defined: adds a second output register stage.
  - Read latency 2: request at N gives data/val at N+2. Throughput is still one read per cycle.
  - Collision bypass is resolved at issue cycle N, and the merged data is carried through the pipe.
  - Both stages reset to 0. Reset flushes in-flight reads, so no rd_val pulses after reset.
- Not defined: single stage, latency 1 as in Behaviour.

Test Plan:
1. Init sweep: release reset with BW_ADDR=4 -> rdy=0 for 16 cycles, then 1. Reading all 16 addresses returns 0x00000000, each rd_val one cycle after its rd_en.
2. Ignore while not ready: wr_en to addr 3 with data 0xDEADBEEF, be=0xF, during INIT -> after rdy, read addr 3 returns 0x00000000; no rd_val during INIT.
3. Byte enables: write 0x11223344 be=0xF to addr 5, then 0xAABBCCDD be=0x5 -> read addr 5 returns 0x11BB33DD.
4. Collision: mem[7]=0x11223344; same cycle write 0xAABBCCDD be=0xC and read addr 7 -> next cycle rd_data=0xAABB3344, rd_val=1. A later read of addr 7 returns 0xAABB3344.
5. Back-to-back and hold: reads of addr 1, 2, 3 on consecutive cycles (contents 0x1, 0x2, 0x3) -> rd_val high 3 consecutive cycles with 0x1, 0x2, 0x3. Then rd_en=0 -> rd_val=0 and rd_data stays 0x3.
6. Reset mid-read: issue a read, assert rstn=0 next cycle -> rd_val=0, rdy=0, rd_data=0. The sweep reruns 16 cycles and prior data reads back 0. With RV_DPSRAM_OREG_EN, rerun scenarios 3–5 expecting a 2-cycle latency.

Source files
------------

// File: rtl/rv_dpsram.sv
// ============================================================================
// Module  : rv_dpsram
// Purpose : 1W/1R synchronous SRAM with byte enables, write-first bypass and
//           a post-reset clearing sweep. RV_DPSRAM_OREG_EN adds an output stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_dpsram #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 4,
  parameter int BW_BE   = BW_DATA / 8
) (
  input  logic               i_dpsram_clk,
  input  logic               i_dpsram_rstn,
  input  logic               i_dpsram_wr_en,
  input  logic [BW_ADDR-1:0] i_dpsram_wr_addr,
  input  logic [BW_DATA-1:0] i_dpsram_wr_data,
  input  logic [BW_BE-1:0]   i_dpsram_wr_be,
  input  logic               i_dpsram_rd_en,
  input  logic [BW_ADDR-1:0] i_dpsram_rd_addr,
  output logic [BW_DATA-1:0] o_dpsram_rd_data,
  output logic               o_dpsram_rd_val,
  output logic               o_dpsram_rdy
);

  localparam int                 DEPTH       = 2 ** BW_ADDR;
  localparam logic [BW_ADDR-1:0] c_last_addr = {BW_ADDR{1'b1}};

  generate
    if (BW_DATA % 8 != 0) begin : g_bad_width
      $error("rv_dpsram: BW_DATA must be a multiple of 8");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BW_ADDR-1:0]   r_cnt;
  logic [BW_ADDR-1:0]   w_cnt_nxt;
  logic                 w_sweep_we;
  logic [BW_DATA-1:0]   r_mem [DEPTH];

  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_collide;
  logic [BW_DATA-1:0]   w_rd_merge;
  logic [BW_DATA-1:0]   r_rd_data;
  logic                 r_rd_val;

  always_ff @(posedge i_dpsram_clk) begin
    if (!i_dpsram_rstn) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter parks on the last address so READY never re-sweeps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sweep_we  = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_sweep_we = 1'b1;
        if (r_cnt == c_last_addr) begin
          w_state_nxt = ST_READY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_dpsram_rdy = (r_state == ST_READY);
  assign w_wr_acc     = o_dpsram_rdy && i_dpsram_wr_en;
  assign w_rd_acc     = o_dpsram_rdy && i_dpsram_rd_en;
  assign w_collide    = w_wr_acc && (i_dpsram_wr_addr == i_dpsram_rd_addr);

  always_ff @(posedge i_dpsram_clk) begin
    if (i_dpsram_rstn) begin
      if (w_sweep_we) begin
        r_mem[r_cnt] <= '0;
      end else if (w_wr_acc) begin
        for (int k = 0; k < BW_BE; k++) begin
          if (i_dpsram_wr_be[k]) begin
            r_mem[i_dpsram_wr_addr][8*k +: 8] <= i_dpsram_wr_data[8*k +: 8];
          end
        end
      end
    end
  end

  // Write-first: bytes being written this cycle override the stored bytes.
  always_comb begin
    w_rd_merge = r_mem[i_dpsram_rd_addr];
    for (int k = 0; k < BW_BE; k++) begin
      if (w_collide && i_dpsram_wr_be[k]) begin
        w_rd_merge[8*k +: 8] = i_dpsram_wr_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_dpsram_clk) begin
    if (!i_dpsram_rstn) begin
      r_rd_val  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_val <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_merge;
      end
    end
  end

`ifdef RV_DPSRAM_OREG_EN
  logic [BW_DATA-1:0] r_rd_data2;
  logic               r_rd_val2;

  always_ff @(posedge i_dpsram_clk) begin
    if (!i_dpsram_rstn) begin
      r_rd_val2  <= 1'b0;
      r_rd_data2 <= '0;
    end else begin
      r_rd_val2 <= r_rd_val;
      if (r_rd_val) begin
        r_rd_data2 <= r_rd_data;
      end
    end
  end

  assign o_dpsram_rd_data = r_rd_data2;
  assign o_dpsram_rd_val  = r_rd_val2;
`else
  assign o_dpsram_rd_data = r_rd_data;
  assign o_dpsram_rd_val  = r_rd_val;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_dpsram.sv
// ============================================================================
// Module  : tb_rv_dpsram
// Purpose : Directed plus random stimulus for rv_dpsram against a reference
//           array model; honours RV_DPSRAM_OREG_EN for the latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_dpsram;

  localparam int DEPTH = 16;
`ifdef RV_DPSRAM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rstn;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_val;
  logic        rdy;

  rv_dpsram #(.BW_DATA(32), .BW_ADDR(4)) dut (
    .i_dpsram_clk     (clk),
    .i_dpsram_rstn    (rstn),
    .i_dpsram_wr_en   (wr_en),
    .i_dpsram_wr_addr (wr_addr),
    .i_dpsram_wr_data (wr_data),
    .i_dpsram_wr_be   (wr_be),
    .i_dpsram_rd_en   (rd_en),
    .i_dpsram_rd_addr (rd_addr),
    .o_dpsram_rd_data (rd_data),
    .o_dpsram_rd_val  (rd_val),
    .o_dpsram_rdy     (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;

  // Reference state: storage contents, clean cycles since reset, read pipe.
  logic [31:0] ref_mem [DEPTH];
  int          since = 0;
  logic        pv [LAT];
  logic [31:0] pd [LAT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [3:0] wa,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic re, input logic [3:0] ra);
    logic        ready, wacc, racc;
    logic [31:0] merged;
    rstn = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    ready  = (since >= DEPTH);
    wacc   = r && ready && we;
    racc   = r && ready && re;
    merged = ref_mem[ra];
    for (int k = 0; k < 4; k++)
      if (wacc && wa == ra && be[k]) merged[8*k +: 8] = wd[8*k +: 8];
    @(posedge clk);
    #1;
    if (!r) begin
      since = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = 32'h0; end
    end else begin
      if (since < DEPTH) since++;
      if (wacc)
        for (int k = 0; k < 4; k++)
          if (be[k]) ref_mem[wa][8*k +: 8] = wd[8*k +: 8];
      for (int i = LAT - 1; i > 0; i--) begin
        if (pv[i-1]) pd[i] = pd[i-1];
        pv[i] = pv[i-1];
      end
      pv[0] = racc;
      if (racc) pd[0] = merged;
    end
    chk("rdy", {31'b0, rdy}, {31'b0, (since >= DEPTH)});
    chk("rd_val", {31'b0, rd_val}, {31'b0, pv[LAT-1]});
    chk("rd_data", rd_data, pd[LAT-1]);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1'b1, 1'b1, a, d, be, 1'b0, 4'h0);
  endtask
  task automatic rd(input logic [3:0] a);
    step(1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, a);
  endtask
  task automatic drain();
    repeat (LAT - 1) idle();
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = 32'h0; end

    // Reset, then a sweep during which requests must be ignored
    repeat (2) step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    for (int c = 0; c < DEPTH; c++)
      step(1'b1, 1'b1, 4'h3, 32'hDEADBEEF, 4'hF, 1'b1, 4'h3);
    chk("rdy_after_sweep", {31'b0, rdy}, 32'h1);

    // Whole array reads back zero, back-to-back
    for (int a = 0; a < DEPTH; a++) rd(4'(a));
    idle();
    drain();

    // Byte enables
    wr(4'h5, 32'h11223344, 4'hF);
    wr(4'h5, 32'hAABBCCDD, 4'h5);
    rd(4'h5);
    drain();
    chk("byte_en", rd_data, 32'h11BB33DD);

    // Write-first collision, then a plain re-read
    wr(4'h7, 32'h11223344, 4'hF);
    step(1'b1, 1'b1, 4'h7, 32'hAABBCCDD, 4'hC, 1'b1, 4'h7);
    drain();
    chk("collide", rd_data, 32'hAABB3344);
    rd(4'h7);
    drain();
    chk("collide_reread", rd_data, 32'hAABB3344);

    // Back-to-back reads then hold
    wr(4'h1, 32'h1, 4'hF);
    wr(4'h2, 32'h2, 4'hF);
    wr(4'h3, 32'h3, 4'hF);
    rd(4'h1); rd(4'h2); rd(4'h3);
    repeat (3) idle();
    chk("hold", rd_data, 32'h3);

    // Random traffic
    for (int c = 0; c < 400; c++)
      step(1'b1, 1'($urandom), 4'($urandom), $urandom, 4'($urandom),
           1'($urandom), 4'($urandom));

    // Reset one cycle after a read issue, then the sweep must clear data
    wr(4'h9, 32'hCAFEF00D, 4'hF);
    rd(4'h9);
    step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    chk("rst_val", {31'b0, rd_val}, 32'h0);
    chk("rst_data", rd_data, 32'h0);
    for (int c = 0; c < DEPTH + 2; c++) idle();
    rd(4'h9);
    drain();
    chk("post_rst_read", rd_data, 32'h0);
    chk("post_rst_val", {31'b0, rd_val}, 32'h1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
